// File: rtl/lotr_pkg.sv
// Shared definitions for the lotr host-terminal front end.
//   - terminal opcode bytes
//   - parser and UART receiver state encodings
//   - size_to_words: byte count -> 32-bit word count, rounded up
package lotr_pkg;

    localparam logic [7:0] TERM_OP_W  = 8'h57;  // 'W' single write
    localparam logic [7:0] TERM_OP_R  = 8'h52;  // 'R' single read
    localparam logic [7:0] TERM_OP_BW = 8'h4A;  // 'J' burst write
    localparam logic [7:0] TERM_OP_BR = 8'h4D;  // 'M' burst read

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        SIZE,
        DATA,
        ISSUE,
        BREAD
    } t_term_state;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } t_uart_rx_state;

    // 33-bit sum so a size near 2^32 does not wrap before the shift; the
    // word counter is 30 bits wide, so the result is truncated to that.
    function automatic logic [29:0] size_to_words(input logic [31:0] size);
        return 30'(({1'b0, size} + 33'd3) >> 2);
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver.
//   QClk, RstQnnnL : clock, async active-low reset
//   UartRx         : serial input, idle high (asynchronous to QClk)
//   ByteValid      : one-cycle pulse, ByteData holds the received byte
//   ByteData[7:0]  : last good byte
//   ErrFrame       : one-cycle pulse when the stop bit is sampled low
module uart_rx_byte
    import lotr_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       QClk,
    input  logic       RstQnnnL,
    input  logic       UartRx,
    output logic       ByteValid,
    output logic [7:0] ByteData,
    output logic       ErrFrame
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    t_uart_rx_state rx_state;
    logic [1:0]     sync;      // sync[1] is the synchronized line
    logic           rx_prev;   // previous synchronized value, for edge detect
    logic [CW-1:0]  cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shreg;

    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            rx_state  <= RX_IDLE;
            sync      <= 2'b11;
            rx_prev   <= 1'b1;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            ByteValid <= 1'b0;
            ByteData  <= '0;
            ErrFrame  <= 1'b0;
        end else begin
            sync      <= {sync[0], UartRx};
            rx_prev   <= sync[1];
            ByteValid <= 1'b0;
            ErrFrame  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (rx_prev && !sync[1])
                        rx_state <= RX_START;
                end
                RX_START: begin
                    // Mid-start-bit recheck filters glitches.
                    if (cnt == HALF_LAST) begin
                        cnt      <= '0;
                        rx_state <= sync[1] ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL_LAST) begin
                        cnt     <= '0;
                        shreg   <= {sync[1], shreg[7:1]};  // LSB first
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7)
                            rx_state <= RX_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    // Back to idle right after the mid-stop sample so the
                    // next start edge is never missed.
                    if (cnt == FULL_LAST) begin
                        cnt      <= '0;
                        rx_state <= RX_IDLE;
                        if (sync[1]) begin
                            ByteValid <= 1'b1;
                            ByteData  <= shreg;
                        end else begin
                            ErrFrame <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_term_cmd.sv
// Host-terminal command front end: UART bytes -> single-word fabric requests.
//   QClk, RstQnnnL : clock, async active-low reset
//   UartRx         : 8N1 serial input from host
//   ReqValid/ReqReady, ReqWrite, ReqAddr, ReqData : request handshake
//   Busy           : parser not idle
//   ErrFrame/ErrOpcode/ErrOverrun/ErrTimeout : one-cycle error pulses
// Commands: W addr data | R addr | J addr size data... | M addr size
// All fields are 32-bit, sent MSB byte first.
module uart_term_cmd
    import lotr_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 50000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic        QClk,
    input  logic        RstQnnnL,
    input  logic        UartRx,
    output logic        ReqValid,
    input  logic        ReqReady,
    output logic        ReqWrite,
    output logic [31:0] ReqAddr,
    output logic [31:0] ReqData,
    output logic        Busy,
    output logic        ErrFrame,
    output logic        ErrOpcode,
    output logic        ErrOverrun,
    output logic        ErrTimeout
);

    localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW       = $clog2(TO_LIMIT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TO_LIMIT - 1);

    logic       byte_valid;
    logic [7:0] byte_data;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .QClk      (QClk),
        .RstQnnnL  (RstQnnnL),
        .UartRx    (UartRx),
        .ByteValid (byte_valid),
        .ByteData  (byte_data),
        .ErrFrame  (ErrFrame)
    );

    t_term_state   state;
    logic [7:0]    op;
    logic [1:0]    bcnt;      // bytes of current field received
    logic [23:0]   sr;        // field bytes received so far
    logic [31:0]   addr;
    logic [29:0]   words;
    logic [TW-1:0] to_cnt;

    logic [31:0] field;
    logic        field_done;
    logic        handshake;
    logic [31:0] addr_nxt;
    logic [29:0] size_words;

    assign field      = {sr, byte_data};
    assign field_done = byte_valid && (bcnt == 2'd3);
    assign handshake  = ReqValid && ReqReady;
    assign addr_nxt   = addr + 32'd4;
    assign size_words = size_to_words(field);
    assign Busy       = (state != IDLE);

    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            state      <= IDLE;
            op         <= '0;
            bcnt       <= '0;
            sr         <= '0;
            addr       <= '0;
            words      <= '0;
            to_cnt     <= '0;
            ReqValid   <= 1'b0;
            ReqWrite   <= 1'b0;
            ReqAddr    <= '0;
            ReqData    <= '0;
            ErrOpcode  <= 1'b0;
            ErrOverrun <= 1'b0;
            ErrTimeout <= 1'b0;
        end else begin
            ErrOpcode  <= 1'b0;
            ErrOverrun <= 1'b0;
            ErrTimeout <= 1'b0;
            case (state)
                IDLE: begin
                    bcnt   <= '0;
                    to_cnt <= '0;
                    if (byte_valid) begin
                        if (byte_data == TERM_OP_W  || byte_data == TERM_OP_R ||
                            byte_data == TERM_OP_BW || byte_data == TERM_OP_BR) begin
                            op    <= byte_data;
                            state <= ADDR;
                        end else begin
                            ErrOpcode <= 1'b1;
                        end
                    end
                end

                ADDR, SIZE, DATA: begin
                    if (byte_valid) begin
                        to_cnt <= '0;
                        sr     <= field[23:0];
                        bcnt   <= bcnt + 1'b1;  // wraps to 0 at field end
                        if (field_done) begin
                            if (state == ADDR) begin
                                addr <= field;
                                if (op == TERM_OP_W) begin
                                    state <= DATA;
                                end else if (op == TERM_OP_R) begin
                                    ReqValid <= 1'b1;
                                    ReqWrite <= 1'b0;
                                    ReqAddr  <= field;
                                    ReqData  <= '0;
                                    state    <= ISSUE;
                                end else begin
                                    state <= SIZE;
                                end
                            end else if (state == SIZE) begin
                                words <= size_words;
                                if (size_words == '0) begin
                                    state <= IDLE;
                                end else if (op == TERM_OP_BW) begin
                                    state <= DATA;
                                end else begin
                                    ReqValid <= 1'b1;
                                    ReqWrite <= 1'b0;
                                    ReqAddr  <= addr;
                                    ReqData  <= '0;
                                    state    <= BREAD;
                                end
                            end else begin
                                ReqValid <= 1'b1;
                                ReqWrite <= 1'b1;
                                ReqAddr  <= addr;
                                ReqData  <= field;
                                state    <= ISSUE;
                            end
                        end
                    end else if (to_cnt == TO_LAST) begin
                        to_cnt     <= '0;
                        ErrTimeout <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                ISSUE: begin
                    to_cnt <= '0;
                    // Burst writes keep collecting the next word while the
                    // current request waits; ReqData holds the pending one.
                    if (op == TERM_OP_BW && byte_valid) begin
                        sr   <= field[23:0];
                        bcnt <= bcnt + 1'b1;
                    end
                    if (handshake) begin
                        ReqValid <= 1'b0;
                        if (op == TERM_OP_BW) begin
                            addr  <= addr_nxt;
                            words <= words - 1'b1;
                            if (words == 30'd1) begin
                                state <= IDLE;
                            end else if (byte_valid && field_done) begin
                                // Next word completed on the accept cycle:
                                // issue it straight away.
                                ReqValid <= 1'b1;
                                ReqWrite <= 1'b1;
                                ReqAddr  <= addr_nxt;
                                ReqData  <= field;
                            end else begin
                                state <= DATA;
                            end
                        end else begin
                            state <= IDLE;
                        end
                    end else if (op == TERM_OP_BW && field_done) begin
                        ErrOverrun <= 1'b1;  // new word dropped, request kept
                    end
                end

                BREAD: begin
                    to_cnt <= '0;
                    if (handshake) begin
                        addr  <= addr_nxt;
                        words <= words - 1'b1;
                        if (words == 30'd1) begin
                            ReqValid <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            ReqAddr <= addr_nxt;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
